// File: rtl/spi_pkg.sv
// Shared definitions for the inter-node SPI receive path.
// SLAVE_SPI_RX_PARITY_EN selects a trailing even-parity bit per frame.
package spi_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

`ifdef SLAVE_SPI_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/slave_spi_rx_if.sv
// Serial link inputs plus the receive-queue side of slave_spi_rx.
interface slave_spi_rx_if
  import spi_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
);
  logic                     sclk_in;
  logic                     cs_in;
  logic                     sdata_in;
  logic                     pop;
  logic [WIDTH-1:0]         data_out;
  logic                     check_out;
  logic [$clog2(DEPTH):0]   count;
  logic                     frame_err;
  logic                     overflow;

  modport slave (
    input  sclk_in, cs_in, sdata_in, pop,
    output data_out, check_out, count, frame_err, overflow
  );

  modport master (
    output sclk_in, cs_in, sdata_in, pop,
    input  data_out, check_out, count, frame_err, overflow
  );
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module spi_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot a simultaneous push needs when full.
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/slave_spi_rx.sv
// SPI slave receiver: synchronise, detect sclk rise, deserialise one word per cs frame, queue it.
// SLAVE_SPI_RX_PARITY_EN adds an even-parity bit after the word.
module slave_spi_rx
  import spi_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  slave_spi_rx_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(WIDTH + PARITY_BITS);

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1;
  logic sdata_p0, sdata_p1;
  logic rise;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] sr;
  logic             extra_q;
  logic             parity_ok;
  logic             push, ferr, clear, shift_en, mark_extra;
  logic             full, empty;

  // Synchroniser stage, plus one delayed sclk copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      cs_p0   <= 1'b0;
      cs_p1   <= 1'b0;
    end else begin
      sclk_p0 <= bus.sclk_in;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= bus.cs_in;
      cs_p1   <= cs_p0;
    end
  end

  always_ff @(posedge clk) begin
    sdata_p0 <= bus.sdata_in;
    sdata_p1 <= sdata_p0;
  end

  assign rise = sclk_p1 & ~sclk_p2;

  // Frame FSM stage
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    ferr       = 1'b0;
    clear      = 1'b0;
    shift_en   = 1'b0;
    mark_extra = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_p1) begin
          clear   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == FRAME_LEN) begin
          push    = parity_ok;
          ferr    = ~parity_ok;
          state_d = DONE;
        end else if (!cs_p1) begin
          ferr    = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          shift_en = 1'b1;
        end
      end
      DONE: begin
        mark_extra = rise;
        if (!cs_p1) begin
          ferr    = extra_q | rise;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      extra_q <= 1'b0;
    end else if (clear) begin
      bit_cnt <= '0;
      extra_q <= 1'b0;
    end else begin
      if (shift_en)   bit_cnt <= bit_cnt + 1'b1;
      if (mark_extra) extra_q <= 1'b1;
    end
  end

`ifdef SLAVE_SPI_RX_PARITY_EN
  logic par_q;

  // The bit after the word lands in par_q so sr keeps the word intact.
  always_ff @(posedge clk) begin
    if (clear) begin
      sr    <= '0;
      par_q <= 1'b0;
    end else if (shift_en) begin
      if (bit_cnt == CNT_W'(WIDTH)) par_q <= sdata_p1;
      else                          sr    <= {sr[WIDTH-2:0], sdata_p1};
    end
  end

  assign parity_ok = ~^{sr, par_q};
`else
  always_ff @(posedge clk) begin
    if (clear)         sr <= '0;
    else if (shift_en) sr <= {sr[WIDTH-2:0], sdata_p1};
  end

  assign parity_ok = 1'b1;
`endif

  // Output queue stage
  spi_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.pop),
    .wdata (sr),
    .rdata (bus.data_out),
    .full  (full),
    .empty (empty),
    .count (bus.count)
  );

  assign bus.check_out = ~empty;
  assign bus.frame_err = ferr;
  assign bus.overflow  = push & full & ~(bus.pop & ~empty);
endmodule

// File: doc/slave_spi_rx.md
# slave_spi_rx

Serial receive endpoint for the inter-node SPI link: the counterpart of the master SPI transmitter that drives `out_instr`/`clk_out`/check lines out of each one-dimensional node. Oversamples the incoming serial clock on the node clock, deserialises one instruction word per chip-select frame, and buffers completed words in a small FIFO. Presents them as a word plus check strobe that feeds one port of the receiver queue.

## Interface
- `WIDTH`, 32, instruction word width in bits
- `DEPTH`, 4, FIFO depth in words; power of two, at least 2

- `clk`  in  1  node clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sclk_in`  in  1  serial clock from the neighbour's master; asynchronous to `clk`
- `cs_in`  in  1  frame select, active-high; asynchronous
- `sdata_in`  in  1  serial data, MSB first; asynchronous
- `data_out`  out  WIDTH  head-of-FIFO word, first-word-fall-through
- `check_out`  out  1  high while the FIFO is non-empty; drives the receiver queue's check input
- `pop`  in  1  consume the head word; ignored when `check_out` is low
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `frame_err`  out  1  one-cycle pulse when a malformed frame is discarded
- `overflow`  out  1  one-cycle pulse when a complete word is dropped because the FIFO is full

## Operation
- Each of `sclk_in`, `cs_in` and `sdata_in` passes through a 2-flop synchroniser.
- An sclk rising edge (`rise`) is detected from the synchronised sclk against a delayed copy.
- FSM states and transitions:
  - IDLE: when synchronised cs is high, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on each `rise`, shift in the synchronised data bit LSB-side (`sr <= {sr[WIDTH-2:0], bit}`) and increment the bit counter. When the counter reaches WIDTH, raise a push request and go to DONE.
  - SHIFT, cs low before WIDTH bits: pulse `frame_err`, discard the partial word, return to IDLE.
  - DONE: ignore further `rise` edges. Stay in DONE until cs goes low, then go to IDLE.
  - DONE, any `rise` seen before cs drops: pulse `frame_err` when cs drops. The captured word is still kept.
- FIFO push when not full: the word is written.
- FIFO push when full with no pop in the same cycle: the word is dropped and `overflow` pulses.
- Push and pop in the same cycle, including when full: both take effect and `count` is unchanged.
- Pop when empty: no effect.
- Bit counter is $clog2(WIDTH)+1 bits wide. FIFO read/write pointers wrap modulo DEPTH.
- Reset values:
  - FSM in IDLE; FIFO empty.
  - `check_out`=0, `count`=0, `frame_err`=0, `overflow`=0.
  - `data_out`=0.
- Reset in mid-frame: the partial word is discarded. After reset, the FSM re-enters SHIFT only on a cs seen high in IDLE, so a frame already in progress is received as a short frame and produces `frame_err`.

## Timing
- Input-to-internal latency: 2 cycles of synchronisation plus 1 cycle of edge detection.
- Let cycle E be the cycle in which `rise` for the last bit is asserted:
  - the shift register holds the full word at the end of E;
  - the push happens at the end of E+1;
  - `check_out` and `data_out` are valid in E+2.
- `pop` sampled high in cycle P: the next word, or `check_out`=0, appears in P+1.
- Link requirement: sclk high and low phases of at least 3 `clk` periods each.
- Link requirement: cs setup and hold of at least 3 `clk` periods around the first and last sclk edges.
- Link requirement: sdata stable for at least 3 `clk` periods around each sclk rising edge.

## Configuration
- `SLAVE_SPI_RX_PARITY_EN` defined:
  - the frame is WIDTH+1 bits; the final bit is even parity over the word;
  - on a mismatch the word is not pushed and `frame_err` pulses in the push cycle;
  - a frame of exactly WIDTH bits is short and produces `frame_err`.
- `SLAVE_SPI_RX_PARITY_EN` undefined: the frame is WIDTH bits with no parity, exactly as described above.

## Structure
- Shared package `spi_pkg` holds:
  - the default word width constant (32);
  - the RX FSM state enum (IDLE, SHIFT, DONE);
  - the parity-bit count constant (0 or 1, selected by the macro).
- One sub-module, `spi_rx_fifo`: parameterised synchronous FWFT FIFO carrying push, pop, full, empty and count.
- The synchroniser, edge detect and FSM stay in the top level.

## Test plan
- Single frame carrying 32'hDEADBEEF MSB first -> `check_out` high; `data_out`=32'hDEADBEEF; `count`=1; no error pulses.
- Five back-to-back frames with no pop, values 1..5, DEPTH=4 -> `count`=4; one `overflow` pulse on the fifth push; pops return 1, 2, 3, 4.
- cs dropped after 17 bits, followed by a good frame of 32'h12345678 -> one `frame_err` pulse; only 32'h12345678 is queued.
- FIFO full, with `pop` and a push landing in the same cycle -> `count` stays 4; no `overflow`; the new word becomes the tail.
- `rst` asserted after 10 bits of a frame -> all outputs at reset values; the remainder of that frame produces `frame_err`; the next frame is received correctly.
- With `SLAVE_SPI_RX_PARITY_EN`:
  - 32'h00000001 with parity bit 1 -> accepted;
  - the same word with parity bit 0 -> `frame_err`, nothing queued.
